// File: rtl/serial_borrow_subtractor_pkg.sv
// rtl/serial_borrow_subtractor_pkg.sv - shared state encoding and sizing helper for the serial subtractor
package serial_borrow_subtractor_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Bit counter is one bit wider than needed to index WIDTH bits.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_borrow_subtractor_if.sv
// rtl/serial_borrow_subtractor_if.sv - start/done operand and result bundle for the serial subtractor
interface serial_borrow_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Bout;

    modport master (
        output start, A, B, Bin,
        input  busy, done, Diff, Bout
    );

    modport slave (
        input  start, A, B, Bin,
        output busy, done, Diff, Bout
    );
endinterface

// File: rtl/serial_borrow_subtractor_full_subtractor.sv
// rtl/serial_borrow_subtractor_full_subtractor.sv - combinational 1-bit full subtractor
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);
    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

// File: rtl/serial_borrow_subtractor.sv
// rtl/serial_borrow_subtractor.sv - bit-serial A - B - Bin, LSB first, behind a start/done handshake
module serial_borrow_subtractor
    import serial_borrow_subtractor_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    serial_borrow_subtractor_if.slave  bus
);
    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic fs_d, fs_bo;
    logic load;

    full_subtractor u_fs (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .bi (borrow_q),
        .d  (fs_d),
        .bo (fs_bo)
    );

    // A new operation is accepted from IDLE, or straight out of DONE for back-to-back use.
    assign load = bus.start && (state_q == S_IDLE || state_q == S_DONE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        if (load) begin
            a_d      = bus.A;
            b_d      = bus.B;
            borrow_d = bus.Bin;
            diff_d   = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
            state_d  = S_SHIFT;
        end else begin
            case (state_q)
                S_SHIFT: begin
                    a_d      = a_q >> 1;
                    b_d      = b_q >> 1;
                    borrow_d = fs_bo;
                    diff_d   = {fs_d, diff_q[WIDTH-1:1]};
                    if (cnt_q == CNT_LAST) begin
                        bout_d  = fs_bo;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_DONE:  state_d = S_IDLE;
                S_IDLE:  state_d = S_IDLE;
                default: begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.Diff = diff_q;
    assign bus.Bout = bout_q;
endmodule
